// File: rtl/usb_pkg.sv
// usb_pkg: shared arbiter state encoding and default buffer depth
package usb_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      HOST_FILL  = 3'd1,
      TX_DRAIN   = 3'd2,
      RX_FILL    = 3'd3,
      HOST_DRAIN = 3'd4
   } state_e;
   localparam int BUF_DEPTH_DEF = 64;
endpackage

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: arbitrates the shared packet buffer between AHB host, USB receiver and USB transmitter
//   in : clk, n_rst, buffer_occupancy, host_store/get/clear_req, rx_active, rx_store_req, tx_active, tx_get_req
//   out: store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data, clear, host_wait, owner, access_err
module buffer_arbiter
   import usb_pkg::*;
#(
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [6:0] buffer_occupancy,
   input  logic       host_store_req,
   input  logic       host_get_req,
   input  logic       host_clear_req,
   input  logic       rx_active,
   input  logic       rx_store_req,
   input  logic       tx_active,
   input  logic       tx_get_req,
   output logic       store_tx_data,
   output logic       get_rx_data,
   output logic       store_rx_packet_data,
   output logic       get_tx_packet_data,
   output logic       clear,
   output logic       host_wait,
   output logic [2:0] owner,
   output logic       access_err
);
   localparam logic [6:0] FULL_LVL = 7'(BUF_DEPTH);
   state_e state_q, state_d;
   logic   rx_q, tx_q, clear_pending_q, clear_pending_d, access_err_q, access_err_d;
   logic   rx_rise, rx_fall, tx_rise, tx_fall, not_full, not_empty, busy, err;
   assign rx_rise   = rx_active & ~rx_q;
   assign rx_fall   = ~rx_active & rx_q;
   assign tx_rise   = tx_active & ~tx_q;
   assign tx_fall   = ~tx_active & tx_q;
   assign not_full  = buffer_occupancy < FULL_LVL;
   assign not_empty = |buffer_occupancy;
   assign busy      = state_q == RX_FILL || state_q == TX_DRAIN;
   assign owner     = state_q;
   assign access_err = access_err_q;
   always_comb begin
      // a clear deferred by a busy packet fires on the first non-busy cycle
      clear = ~busy & (host_clear_req | clear_pending_q);
      store_tx_data = ~clear & host_store_req & (state_q == IDLE || state_q == HOST_FILL) & not_full & ~rx_rise;
      get_rx_data = ~clear & host_get_req & state_q == HOST_DRAIN & not_empty;
      store_rx_packet_data = ~clear & rx_store_req & state_q == RX_FILL & not_full;
      get_tx_packet_data = ~clear & tx_get_req & state_q == TX_DRAIN & not_empty;
      host_wait = (host_store_req | host_get_req | host_clear_req) & busy;
      clear_pending_d = busy & (clear_pending_q | host_clear_req);
      err = (host_store_req & (~not_full | state_q == HOST_DRAIN))
          | (host_get_req & (state_q != HOST_DRAIN | ~not_empty))
          | (rx_store_req & ~not_full)
          | (tx_get_req & ~not_empty)
          | (rx_rise & state_q != IDLE);
      access_err_d = clear ? 1'b0 : access_err_q | err;
      state_d = state_q;
      case (state_q)
         IDLE:       state_d = rx_rise ? RX_FILL : host_store_req ? HOST_FILL : IDLE;
         HOST_FILL:  state_d = tx_rise ? TX_DRAIN : HOST_FILL;
         RX_FILL:    state_d = rx_fall ? (not_empty ? HOST_DRAIN : IDLE) : RX_FILL;
         TX_DRAIN:   state_d = tx_fall ? IDLE : TX_DRAIN;
         HOST_DRAIN: state_d = (get_rx_data && buffer_occupancy == 7'd1) ? IDLE : HOST_DRAIN;
         default:    state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= IDLE;
         rx_q            <= 1'b0;
         tx_q            <= 1'b0;
         clear_pending_q <= 1'b0;
         access_err_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         rx_q            <= rx_active;
         tx_q            <= tx_active;
         clear_pending_q <= clear_pending_d;
         access_err_q    <= access_err_d;
      end
   end
endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter: directed per-cycle vectors for buffer_arbiter plus async reset corner case
module tb_buffer_arbiter;
   localparam logic [6:0] HS = 7'b1000000, HG = 7'b0100000, HC = 7'b0010000, RXA = 7'b0001000,
                          RXS = 7'b0000100, TXA = 7'b0000010, TXG = 7'b0000001, NO = 7'b0;
   localparam logic [4:0] ST = 5'b10000, GR = 5'b01000, SR = 5'b00100, GT = 5'b00010, CL = 5'b00001, N = 5'b0;
   logic clk = 1'b0, n_rst = 1'b0;
   logic [6:0] occ = '0;
   logic hs = 0, hg = 0, hc = 0, rxa = 0, rxs = 0, txa = 0, txg = 0;
   logic store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data, clear, host_wait, access_err;
   logic [2:0] owner;
   logic [4:0] strb;
   logic [9:0] obs;
   int pass_cnt = 0, total = 0;
   typedef struct {
      logic [6:0] occ;
      logic [6:0] in;
      logic [4:0] strb;
      logic       w;
      logic [2:0] own;
      logic       err;
   } vec_t;
   vec_t v[$];
   buffer_arbiter dut (
      .clk(clk), .n_rst(n_rst), .buffer_occupancy(occ),
      .host_store_req(hs), .host_get_req(hg), .host_clear_req(hc),
      .rx_active(rxa), .rx_store_req(rxs), .tx_active(txa), .tx_get_req(txg),
      .store_tx_data(store_tx_data), .get_rx_data(get_rx_data),
      .store_rx_packet_data(store_rx_packet_data), .get_tx_packet_data(get_tx_packet_data),
      .clear(clear), .host_wait(host_wait), .owner(owner), .access_err(access_err)
   );
   always #5 clk = ~clk;
   assign strb = {store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data, clear};
   assign obs  = {strb, host_wait, owner, access_err};
   task automatic add(input logic [6:0] o, input logic [6:0] i, input logic [4:0] s,
                      input logic w, input logic [2:0] ow, input logic e);
      vec_t t;
      t.occ = o; t.in = i; t.strb = s; t.w = w; t.own = ow; t.err = e;
      v.push_back(t);
   endtask
   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got strb=%b wait=%b owner=%0d err=%b expected strb=%b wait=%b owner=%0d err=%b",
                    name, got[9:5], got[4], got[3:1], got[0], exp[9:5], exp[4], exp[3:1], exp[0]);
   endtask
   initial begin
      // host fill 4 bytes, tx drain over a 20-cycle tx_active pulse
      add(0, NO, N, 0, 0, 0);
      add(0, HS, ST, 0, 0, 0);
      add(1, HS, ST, 0, 1, 0);
      add(2, HS, ST, 0, 1, 0);
      add(3, HS, ST, 0, 1, 0);
      add(4, TXA, N, 0, 1, 0);
      add(4, TXA | TXG, GT, 0, 2, 0);
      add(3, TXA | TXG, GT, 0, 2, 0);
      add(2, TXA | TXG, GT, 0, 2, 0);
      add(1, TXA | TXG, GT, 0, 2, 0);
      for (int i = 0; i < 15; i++) add(0, TXA, N, 0, 2, 0);
      add(0, NO, N, 0, 2, 0);
      add(0, NO, N, 0, 0, 0);
      // rx packet of 3 bytes, host drains, IDLE in cycle of third get
      add(0, RXA, N, 0, 0, 0);
      add(0, RXA | RXS, SR, 0, 3, 0);
      add(1, RXA | RXS, SR, 0, 3, 0);
      add(2, RXA | RXS, SR, 0, 3, 0);
      add(3, NO, N, 0, 3, 0);
      add(3, HG, GR, 0, 4, 0);
      add(2, HG, GR, 0, 4, 0);
      add(1, HG, GR, 0, 4, 0);
      add(0, NO, N, 0, 0, 0);
      // rx overflow, then clear in HOST_DRAIN wipes access_err
      add(63, RXA, N, 0, 0, 0);
      add(64, RXA | RXS, N, 0, 3, 0);
      add(64, RXA, N, 0, 3, 1);
      add(64, NO, N, 0, 3, 1);
      add(64, HC, CL, 0, 4, 1);
      add(0, NO, N, 0, 0, 0);
      // clear during TX_DRAIN deferred until after tx_active falls
      add(0, HS, ST, 0, 0, 0);
      add(1, TXA, N, 0, 1, 0);
      add(1, TXA | HC, N, 1, 2, 0);
      add(1, TXA | TXG, GT, 0, 2, 0);
      add(0, NO, N, 0, 2, 0);
      add(0, NO, CL, 0, 0, 0);
      add(0, NO, N, 0, 0, 0);
      // host get outside HOST_DRAIN, and tx underrun, both flag access_err
      add(0, HG, N, 0, 0, 0);
      add(0, NO, N, 0, 0, 1);
      add(0, HC, CL, 0, 0, 1);
      add(0, TXG, N, 0, 0, 0);
      add(0, HC, CL, 0, 0, 1);
      // rx rise while in HOST_FILL: store denied, error, state kept
      add(0, HS, ST, 0, 0, 0);
      add(1, HS | RXA, N, 0, 1, 0);
      add(1, RXA, N, 0, 1, 1);
      add(1, RXA | RXS, N, 0, 1, 1);
      add(1, RXA | HC, CL, 0, 1, 1);
      add(0, RXA, N, 0, 0, 0);
      add(0, NO, N, 0, 0, 0);
      add(0, RXA, N, 0, 0, 0);
      add(0, RXA | RXS, SR, 0, 3, 0);
      // reset state while n_rst is held low
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", obs, 10'b0);
      @(posedge clk); #1 n_rst = 1'b1;
      foreach (v[k]) begin
         {hs, hg, hc, rxa, rxs, txa, txg} = v[k].in;
         occ = v[k].occ;
         @(negedge clk);
         check($sformatf("vec%0d", k), obs, {v[k].strb, v[k].w, v[k].own, v[k].err});
         @(posedge clk); #1;
      end
      // async reset in the middle of RX_FILL drops ownership with no clear
      {hs, hg, hc, rxa, rxs, txa, txg} = RXA | RXS;
      occ = 1;
      #1 check("pre_reset_rx_fill", obs, {SR, 1'b0, 3'd3, 1'b0});
      n_rst = 1'b0;
      #1 check("async_reset_mid_rx", obs, 10'b0);
      {hs, hg, hc, rxa, rxs, txa, txg} = NO;
      occ = 0;
      @(posedge clk); #1 n_rst = 1'b1;
      @(negedge clk);
      check("post_reset_idle", obs, 10'b0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 64, meaning data-buffer capacity in bytes.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port buffer_occupancy, input, 7, current byte count of the shared buffer (0..BUF_DEPTH).
REQ-005 SHALL have ports host_store_req, host_get_req, host_clear_req, inputs, 1 each: AHB-side write-byte, read-byte and clear requests.
REQ-006 SHALL have ports rx_active and rx_store_req, inputs, 1 each: receiver packet-in-progress and receiver byte-write request.
REQ-007 SHALL have ports tx_active and tx_get_req, inputs, 1 each: transmitter packet-in-progress and transmitter byte-read request.
REQ-008 SHALL have outputs store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data, clear, 1 each: granted buffer strobes.
REQ-009 SHALL have output host_wait, 1: host access stalled this cycle (drives AHB wait state).
REQ-010 SHALL have output owner, 3: encoded FSM state; output access_err, 1: sticky protocol-violation flag.

Function
REQ-011 SHALL implement FSM states IDLE=0, HOST_FILL=1, TX_DRAIN=2, RX_FILL=3, HOST_DRAIN=4; owner equals state.
REQ-012 SHALL register rx_active and tx_active once internally; rise/fall are edges of the live input versus the registered copy.
REQ-013 IDLE -> RX_FILL on rx_active rise (highest priority); IDLE -> HOST_FILL on host_store_req when no rx rise.
REQ-014 HOST_FILL -> TX_DRAIN on tx_active rise; RX_FILL -> HOST_DRAIN on rx_active fall if occupancy > 0, else -> IDLE.
REQ-015 TX_DRAIN -> IDLE on tx_active fall; HOST_DRAIN -> IDLE in the cycle get_rx_data fires with occupancy == 1.
REQ-016 Grants combinational, zero latency: store_tx_data = host_store_req AND state in {IDLE, HOST_FILL} AND occupancy < BUF_DEPTH AND no rx rise.
REQ-017 get_rx_data = host_get_req AND state == HOST_DRAIN AND occupancy > 0.
REQ-018 store_rx_packet_data = rx_store_req AND state == RX_FILL AND occupancy < BUF_DEPTH.
REQ-019 get_tx_packet_data = tx_get_req AND state == TX_DRAIN AND occupancy > 0.
REQ-020 host_wait = (host_store_req OR host_get_req OR host_clear_req) AND state in {RX_FILL, TX_DRAIN}.
REQ-021 access_err SHALL set (next cycle) on: host store when full or in HOST_DRAIN; host get outside HOST_DRAIN or when empty; rx store when full (overflow); tx get when empty (underrun); rx_active rise outside IDLE.
REQ-022 rx_active rise outside IDLE SHALL not change state; rx stores in that packet are not granted.
REQ-023 host_clear_req in IDLE/HOST_FILL/HOST_DRAIN SHALL pulse clear one cycle (combinational) and force next state IDLE.
REQ-024 host_clear_req in RX_FILL/TX_DRAIN SHALL set clear_pending; clear pulses one cycle on the first cycle in a non-busy state, then pending drops.
REQ-025 A clear pulse SHALL also reset access_err to 0; otherwise access_err holds.
REQ-026 At most one strobe of store/get/clear SHALL be asserted per cycle; clear overrides and suppresses same-cycle grants.

Reset
REQ-027 On n_rst low: state IDLE, edge registers 0, clear_pending 0, access_err 0; all strobes and host_wait 0 combinationally from that state.
REQ-028 Reset mid-packet SHALL abandon ownership without issuing clear; buffer reset handled by its own reset.

Structure
REQ-029 State enum and BUF_DEPTH default SHALL live in shared package usb_pkg.
REQ-030 No sub-module; single FSM plus grant logic, instantiated between ahb_slave and buffer in usb_top_level.

Verification
REQ-031 Host writes 4 bytes from IDLE, tx_active pulses 20 cycles with 4 tx_get_req -> owner 1 then 2 then 0, 4 store and 4 get strobes, access_err 0.
REQ-032 rx_active rise, 3 rx_store_req, fall; host 3 gets -> owner 3,4,0; returns to IDLE in cycle of third get.
REQ-033 Occupancy 64 in RX_FILL with rx_store_req -> no strobe, access_err 1 next cycle.
REQ-034 host_clear_req during TX_DRAIN -> host_wait 1, no clear; clear pulses exactly one cycle after tx_active fall, access_err 0.
REQ-035 Host store while in HOST_FILL and rx_active rises same cycle -> store denied, access_err 1, state unchanged; n_rst low mid-RX_FILL -> owner 0 immediately.
